// File: rtl/pkt_stream_pkg.sv
// Shared types, default widths and LFSR tap masks for the packet stream generator.
package pkt_stream_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_e;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_LEN_W  = 8;
    localparam int DEF_GAP_W  = 8;
    localparam int DEF_CNT_W  = 16;

    localparam logic [31:0] TAPS_8  = 32'h0000_00B8;
    localparam logic [31:0] TAPS_16 = 32'h0000_B400;
    localparam logic [31:0] TAPS_32 = 32'h8020_0003;

    // Maximal-length Fibonacci tap masks; unsupported widths fall back to 8-bit taps.
    function automatic logic [31:0] lfsr_taps(input int w);
        logic [31:0] t;
        case (w)
            16:      t = TAPS_16;
            32:      t = TAPS_32;
            default: t = TAPS_8;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/pkt_stream_gen_lfsr.sv
// Fibonacci LFSR, left-shifting, seeded to all-ones on reset.
module pkt_lfsr
    import pkt_stream_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));

    logic [W-1:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (step) begin
            lfsr_d = {lfsr_q[W-2:0], ^(lfsr_q & TAPS)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= '1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/pkt_stream_gen.sv
// Programmable packet-stream source: length, gap, enable/drain and packet counter.
// Define PKT_STREAM_GEN_LFSR_EN to add the mode input selecting LFSR payload.
module pkt_stream_gen
    import pkt_stream_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int GAP_W  = DEF_GAP_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [LEN_W-1:0]  pkt_len,
    input  logic [GAP_W-1:0]  gap_len,
`ifdef PKT_STREAM_GEN_LFSR_EN
    input  logic              mode,
`endif
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic [CNT_W-1:0]  pkt_cnt
);

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   beat_q, beat_d;
    logic [GAP_W-1:0]   gapl_q, gapl_d;
    logic [GAP_W-1:0]   gcnt_q, gcnt_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               fire;
    logic               last;
    logic               start;

    // Valid is a pure function of registered state, so ready never reaches it.
    assign m_valid = (state_q == SEND);
    assign last    = (beat_q == len_q - LEN_W'(1));
    assign fire    = m_valid && m_ready;
    assign m_last  = m_valid && last;
    assign busy    = (state_q != IDLE);
    assign pkt_cnt = cnt_q;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        beat_d  = beat_q;
        gapl_d  = gapl_q;
        gcnt_d  = gcnt_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        start   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en) begin
                    start   = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (fire) begin
                    beat_d = beat_q + LEN_W'(1);
                    data_d = data_q + DATA_W'(1);
                    if (last) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (gapl_q != '0) begin
                            state_d = GAP;
                            gcnt_d  = '0;
                        end else if (en) begin
                            start = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            GAP: begin
                if (gcnt_q == gapl_q - GAP_W'(1)) begin
                    if (en) begin
                        start   = 1'b1;
                        state_d = SEND;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gcnt_d = gcnt_q + GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // A zero length would never hit its last beat, so it runs as one beat.
        if (start) begin
            len_d  = (pkt_len == '0) ? LEN_W'(1) : pkt_len;
            gapl_d = gap_len;
            beat_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            beat_q  <= '0;
            gapl_q  <= '0;
            gcnt_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            gapl_q  <= gapl_d;
            gcnt_q  <= gcnt_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PKT_STREAM_GEN_LFSR_EN
    logic              mode_q;
    logic [DATA_W-1:0] lfsr;

    pkt_lfsr #(
        .W (DATA_W)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .step (fire),
        .q    (lfsr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= 1'b0;
        end else if (start) begin
            mode_q <= mode;
        end
    end

    assign m_data = mode_q ? lfsr : data_q;
`else
    assign m_data = data_q;
`endif

endmodule

// File: tb/tb_pkt_stream_gen.sv
// Self-checking bench for pkt_stream_gen against a beat-queue reference model.
module tb_pkt_stream_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] pkt_len;
    logic [7:0] gap_len;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;
    logic       busy;
    logic [15:0] pkt_cnt;
`ifdef PKT_STREAM_GEN_LFSR_EN
    logic       mode = 1'b0;
`endif

    pkt_stream_gen dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .pkt_len (pkt_len),
        .gap_len (gap_len),
`ifdef PKT_STREAM_GEN_LFSR_EN
        .mode    (mode),
`endif
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last),
        .busy    (busy),
        .pkt_cnt (pkt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } beat_t;

    beat_t expq[$];
    int    dctr;
    int    exp_pkts;
    int    checks;
    int    errors;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected packet: zero length runs as one beat, data counts on mod 256.
    task automatic add_pkt(input int len);
        int n;
        n = (len == 0) ? 1 : len;
        for (int i = 0; i < n; i++) begin
            expq.push_back('{d: 8'(dctr), l: (i == n - 1)});
            dctr++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock with scoreboard on transfers and hold-check on stalls.
    task automatic step();
        bit         fire, stall, lst;
        logic [7:0] sd;
        logic       sl;
        beat_t      b;
        fire  = m_valid && m_ready;
        stall = m_valid && !m_ready;
        sd    = m_data;
        sl    = m_last;
        lst   = 1'b0;
        if (fire) begin
            checks++;
            assert (expq.size() != 0) else begin
                errors++;
                $error("FAIL spurious_beat got=%0h exp=none", m_data);
            end
            if (expq.size() != 0) begin
                b = expq.pop_front();
                chk("beat_data", m_data, b.d);
                chk("beat_last", m_last, b.l);
                lst = b.l;
                if (b.l) exp_pkts++;
            end
        end
        tick();
        if (stall) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_data", m_data, sd);
            chk("hold_last", m_last, sl);
        end
        if (lst) chk("pkt_cnt", pkt_cnt, 32'(exp_pkts & 16'hFFFF));
    endtask

    task automatic drain(input bit rnd);
        int n;
        n = 0;
        while (expq.size() > 0 && n < 2000) begin
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            n++;
        end
        chk("drain_left", expq.size(), 0);
    endtask

    initial begin
        int g, k, ln;
        logic [7:0] first;
        checks   = 0;
        errors   = 0;
        dctr     = 0;
        exp_pkts = 0;
        rst      = 1'b1;
        en       = 1'b0;
        pkt_len  = 8'd0;
        gap_len  = 8'd0;
        m_ready  = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_valid", m_valid, 0);
        chk("rst_last", m_last, 0);
        chk("rst_data", m_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", pkt_cnt, 0);

        // len 4, gap 3, two packets
        en = 1'b1; pkt_len = 8'd4; gap_len = 8'd3;
        add_pkt(4);
        add_pkt(4);
        step();
        chk("start_lat", m_valid, 1);
        repeat (4) step();
        for (int i = 0; i < 3; i++) begin
            chk("gap_valid", m_valid, 0);
            chk("gap_busy", busy, 1);
            step();
        end
        chk("gap_end", m_valid, 1);
        en = 1'b0;
        repeat (4) step();
        chk("two_pkts", pkt_cnt, 2);
        repeat (3) step();
        chk("idle_busy", busy, 0);
        chk("idle_valid", m_valid, 0);
        chk("t1_left", expq.size(), 0);

        // back-to-back, len 2, gap 0
        en = 1'b1; pkt_len = 8'd2; gap_len = 8'd0;
        add_pkt(2); add_pkt(2); add_pkt(2);
        step();
        for (int i = 0; i < 6; i++) begin
            chk("b2b_valid", m_valid, 1);
            if (i == 5) en = 1'b0;
            step();
        end
        chk("b2b_idle", busy, 0);

        // stalls then random ready
        en = 1'b1; pkt_len = 8'd4; gap_len = 8'd0;
        add_pkt(4);
        step();
        en = 1'b0;
        m_ready = 1'b0;
        repeat (8) step();
        drain(1'b1);
        m_ready = 1'b1;
        step();
        chk("stall_idle", busy, 0);

        // en dropped mid-packet, length change ignored
        en = 1'b1; pkt_len = 8'd5; gap_len = 8'd0;
        add_pkt(5);
        step();
        step();
        en = 1'b0; pkt_len = 8'd2; gap_len = 8'd7;
        drain(1'b0);
        chk("drop_busy", busy, 0);
        chk("drop_cnt", pkt_cnt, 32'(exp_pkts));

        // random packets with gap measurement
        for (int it = 0; it < 20; it++) begin
            ln = $urandom_range(0, 6);
            g  = $urandom_range(0, 3);
            en = 1'b1; pkt_len = 8'(ln); gap_len = 8'(g);
            add_pkt(ln);
            step();
            en = 1'b0;
            pkt_len = 8'($urandom);
            gap_len = 8'($urandom_range(0, 9));
            drain(1'b1);
            k = 0;
            while (busy && k < 300) begin
                chk("rgap_valid", m_valid, 0);
                step();
                k++;
            end
            chk("rgap_len", k, g);
        end

        // reset mid-packet
        en = 1'b1; pkt_len = 8'd6; gap_len = 8'd0; m_ready = 1'b1;
        add_pkt(6);
        step();
        step();
        step();
        rst = 1'b1; en = 1'b0;
        tick();
        rst = 1'b0;
        expq.delete();
        dctr = 0;
        exp_pkts = 0;
        chk("mrst_valid", m_valid, 0);
        chk("mrst_data", m_data, 0);
        chk("mrst_cnt", pkt_cnt, 0);
        chk("mrst_busy", busy, 0);
        en = 1'b1; pkt_len = 8'd3;
        add_pkt(3);
        step();
        chk("restart_data", m_data, 0);
        en = 1'b0;
        drain(1'b0);

        // zero length, data wrap over 300 one-beat packets
        en = 1'b1; pkt_len = 8'd0; gap_len = 8'd0;
        for (int i = 0; i < 300; i++) add_pkt(0);
        step();
        for (int i = 0; i < 300; i++) begin
            if (i == 299) en = 1'b0;
            step();
        end
        chk("wrap_left", expq.size(), 0);
        chk("wrap_busy", busy, 0);
        chk("wrap_cnt", pkt_cnt, 32'(exp_pkts));

`ifdef PKT_STREAM_GEN_LFSR_EN
        mode = 1'b1; en = 1'b1; pkt_len = 8'd1; gap_len = 8'd0;
        tick();
        first = m_data;
        for (int i = 0; i < 255; i++) begin
            checks++;
            assert (m_data !== 8'h00) else begin
                errors++;
                $error("FAIL lfsr_zero got=%0h exp=nonzero", m_data);
            end
            if (i > 0) begin
                checks++;
                assert (m_data !== first) else begin
                    errors++;
                    $error("FAIL lfsr_short got=%0h at %0d", m_data, i);
                end
            end
            tick();
        end
        chk("lfsr_period", m_data, first);
        en = 1'b0;
        tick();
        mode = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pkt_stream_gen.md
Name: pkt_stream_gen

Overview:
- Parametrised packet-stream traffic generator; next generation of the fixed 4-beat/20-cycle source.
- Drives a valid/ready/last/data master stream into muxes, FIFOs and sinks under test.
- Runtime-programmable packet length and inter-packet gap, clean enable/drain behaviour, and a running packet counter.

Parameters:
- DATA_W, 8, width of m_data; data counter wraps modulo 2^DATA_W.
- LEN_W, 8, width of pkt_len input.
- GAP_W, 8, width of gap_len input.
- CNT_W, 16, width of pkt_cnt output.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  generator enable; sampled in IDLE and at packet boundaries.
- pkt_len  in  LEN_W  beats per packet; latched at packet start; 0 treated as 1.
- gap_len  in  GAP_W  idle cycles after each packet; latched at packet start.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready from sink.
- m_data  out  DATA_W  payload.
- m_last  out  1  final beat of packet; qualified by m_valid.
- busy  out  1  high in SEND or GAP.
- pkt_cnt  out  CNT_W  completed packets; wraps.

Behaviour:
- Reset: one clk with rst high clears state to IDLE. m_valid=0, m_last=0, m_data=0, busy=0, pkt_cnt=0, beat and gap counters=0. Same behaviour if rst arrives mid-packet; the packet is abandoned with no drain.
- Handshake: a beat transfers when m_valid && m_ready. Once m_valid is high, m_valid, m_data and m_last hold stable until the transfer completes. No combinational path from m_ready to m_valid.
- FSM states: IDLE, SEND, GAP.
- IDLE:
  - en=1 latches pkt_len/gap_len, clears beat counter and goes to SEND.
  - m_valid rises the cycle after en is seen high, giving 1-cycle start latency.
- SEND:
  - m_valid=1. m_last = (beat_cnt == len_q-1).
  - Each transfer: beat_cnt+1 and data counter+1, modulo 2^DATA_W, continuing across packets.
  - Transfer with m_last: pkt_cnt+1. Next state is:
    - GAP if gap_q>0;
    - else SEND with new lengths latched if en=1 (back-to-back; m_valid stays high);
    - else IDLE.
- GAP:
  - m_valid=0 for exactly gap_q cycles.
  - Then: en=1 → SEND with new pkt_len/gap_len latched; en=0 → IDLE.
- en deasserted mid-packet: current packet completes in full; never truncated.
- pkt_len/gap_len changes mid-packet: no effect until next packet start.
- m_ready held low: generator stalls indefinitely in SEND; counters frozen.
- pkt_len=1: every beat has m_last=1.
- busy = (state != IDLE).

Optional Feature:
- Macro: PKT_STREAM_GEN_LFSR_EN.
- Defined:
  - Adds input mode (1 bit, latched at packet start). mode=1 sources m_data from a Fibonacci LFSR of width DATA_W, seed all-ones on reset, advancing once per transfer. mode=0 uses the incrementing counter.
  - The LFSR never reaches zero.
- Undefined: no mode port; m_data is always the incrementing counter.

Decomposition:
- Package pkt_stream_pkg:
  - state typedef {IDLE, SEND, GAP};
  - LFSR tap constants per supported DATA_W (8, 16, 32);
  - default widths.
- One sub-module, pkt_lfsr: parametrised width, enable/step input, synchronous reset to seed. Instantiated only when PKT_STREAM_GEN_LFSR_EN is defined.

Test Plan:
- Reset, then en=1, pkt_len=4, gap_len=3, m_ready=1 → m_valid first high 1 cycle after en. Data 0,1,2,3 with m_last on 3. m_valid low exactly 3 cycles, then data 4..7. pkt_cnt=2 after second last.
- gap_len=0, pkt_len=2, m_ready=1 → m_valid continuous. m_last on data 1,3,5. No idle cycle between packets.
- pkt_len=4, m_ready toggled 1,0,0,1,… → data/last held stable while m_ready=0. Beats 0..3 delivered in order, none dropped or repeated.
- en dropped after beat 1 of pkt_len=5 → beats 2..4 still delivered, m_last on 4. Then IDLE with busy=0 and pkt_cnt incremented.
- rst asserted mid-packet (after beat 2) → next cycle m_valid=0, m_data=0, pkt_cnt=0. Restart yields data 0.
- DATA_W=8, pkt_len=0 → treated as 1, m_last on every beat. Data wraps 255→0 after 256 beats. LFSR build with mode=1: sequence period 255, never 0.
